fp_addsub_arbiter: RTL and testbench

FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

---
 rtl/fp_addsub_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_arbiter.sv
// Two-requester front end for one shared floating-point add/sub unit.
// Grants one job at a time with round-robin tie-breaking, launches the
// unit, waits for its completion or a timeout, and returns the response
// to the granted requester.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no job; sample req0/req1 and latch the winner's operands
// S_START | gnt and add_start pulse for the winner
// S_WAIT  | waiting on add_done; cycle counter runs toward timeout
// S_RESP  | rsp_valid pulse for the winner with result/ovf/err
module fp_addsub_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        mode0,
  input  logic        mode1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  output logic [31:0] rsp_result,
  output logic        rsp_ovf,
  output logic        rsp_err,
  output logic        add_start,
  output logic        mode,
  output logic [31:0] op1,
  output logic [31:0] op2,
  input  logic [31:0] add_result,
  input  logic        add_done,
  input  logic        add_overflow,
  output logic        busy
);

  // Counter only needs to reach TIMEOUT_CYCLES-1 (last WAIT cycle).
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Doubles as the winner of the job in flight (1 = requester 1).
  logic             last_grant_q, last_grant_d;
  logic             win1;

  logic        gnt0_d, gnt1_d, rsp_valid0_d, rsp_valid1_d;
  logic [31:0] rsp_result_d, op1_d, op2_d;
  logic        rsp_ovf_d, rsp_err_d, add_start_d, mode_d, busy_d;

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    add_start_d  = 1'b0;
    rsp_valid0_d = 1'b0;
    rsp_valid1_d = 1'b0;
    rsp_result_d = rsp_result;
    rsp_ovf_d    = rsp_ovf;
    rsp_err_d    = rsp_err;
    mode_d       = mode;
    op1_d        = op1;
    op2_d        = op2;
    // Requester 1 wins when alone, or on a tie when 0 was granted last.
    win1         = req1 & (~req0 | ~last_grant_q);

    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d      = S_START;
          last_grant_d = win1;
          gnt0_d       = ~win1;
          gnt1_d       = win1;
          add_start_d  = 1'b1;
          mode_d       = win1 ? mode1 : mode0;
          op1_d        = win1 ? a1 : a0;
          op2_d        = win1 ? b1 : b0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // Completion takes priority over a timeout in the same cycle.
        if (add_done) begin
          state_d      = S_RESP;
          rsp_result_d = add_result;
          rsp_ovf_d    = add_overflow;
          rsp_err_d    = 1'b0;
          rsp_valid0_d = ~last_grant_q;
          rsp_valid1_d = last_grant_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          rsp_result_d = '0;
          rsp_ovf_d    = 1'b0;
          rsp_err_d    = 1'b1;
          rsp_valid0_d = ~last_grant_q;
          rsp_valid1_d = last_grant_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rsp_valid0   <= 1'b0;
      rsp_valid1   <= 1'b0;
      rsp_result   <= '0;
      rsp_ovf      <= 1'b0;
      rsp_err      <= 1'b0;
      add_start    <= 1'b0;
      mode         <= 1'b0;
      op1          <= '0;
      op2          <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt0         <= gnt0_d;
      gnt1         <= gnt1_d;
      rsp_valid0   <= rsp_valid0_d;
      rsp_valid1   <= rsp_valid1_d;
      rsp_result   <= rsp_result_d;
      rsp_ovf      <= rsp_ovf_d;
      rsp_err      <= rsp_err_d;
      add_start    <= add_start_d;
      mode         <= mode_d;
      op1          <= op1_d;
      op2          <= op2_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter: directed scenarios plus randomized jobs,
// each checked against a job-level model (round-robin winner, response
// latency = min(unit latency, timeout), result/flags from the unit model).
module tb_fp_addsub_arbiter;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req0, req1, mode0, mode1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, rsp_valid0, rsp_valid1;
  logic [31:0] rsp_result;
  logic        rsp_ovf, rsp_err, add_start, mode, busy;
  logic [31:0] op1, op2, add_result;
  logic        add_done, add_overflow;
  logic        unit_done, stray_done;

  int n_cmp = 0;
  int n_bad = 0;
  int last_w = 1;
  int unit_lat = 0;
  int unit_cnt = 0;
  bit unit_ovf_force = 1'b0;
  logic [31:0] res_seen;

  assign add_done = unit_done | stray_done;

  always #5 clk = ~clk;

  fp_addsub_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .add_start(add_start), .mode(mode), .op1(op1), .op2(op2),
    .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Single-precision <-> real for normal operands (unit behaviour model).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'({3'b000, f[30:23]}) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] fe;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    fe = d[62:52] - 11'd896;
    return {d[63], fe[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_op(input logic [31:0] x, input logic [31:0] y, input logic m);
    return r2f(m ? (f2r(x) - f2r(y)) : (f2r(x) + f2r(y)));
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // Shared add/sub unit: answers unit_lat cycles after add_start (0 = never).
  initial begin
    unit_done    = 1'b0;
    add_result   = 32'd0;
    add_overflow = 1'b0;
    forever begin
      @(negedge clk);
      unit_done = 1'b0;
      if (add_start) begin
        unit_cnt     = unit_lat;
        add_result   = unit_ovf_force ? 32'h7F800000 : fp_op(op1, op2, mode);
        add_overflow = unit_ovf_force;
      end else if (unit_cnt > 0) begin
        unit_cnt--;
        if (unit_cnt == 0) unit_done = 1'b1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_ovf, rsp_err, add_start, mode, busy}), 64'd0);
    chk({tag, "_res"}, 64'(rsp_result), 64'd0);
    chk({tag, "_op1"}, 64'(op1), 64'd0);
    chk({tag, "_op2"}, 64'(op2), 64'd0);
  endtask

  // One job from IDLE to IDLE; entered and left just after a negedge.
  task automatic do_job(input bit r0, input bit r1, input bit m0, input bit m1,
                        input logic [31:0] xa0, input logic [31:0] xb0,
                        input logic [31:0] xa1, input logic [31:0] xb1,
                        input int lat, input bit ovf, input bit hold,
                        output logic [31:0] got_res);
    int w, n, wexp;
    logic [31:0] e_op1, e_op2, e_res;
    logic e_mode, e_ovf, e_err;
    req0 = r0; req1 = r1; mode0 = m0; mode1 = m1;
    a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
    unit_lat = lat; unit_ovf_force = ovf;
    w = (r0 && r1) ? (1 - last_w) : (r1 ? 1 : 0);
    e_op1  = (w == 1) ? xa1 : xa0;
    e_op2  = (w == 1) ? xb1 : xb0;
    e_mode = (w == 1) ? m1 : m0;
    if (lat != 0 && lat <= T) begin
      wexp = lat; e_res = ovf ? 32'h7F800000 : fp_op(e_op1, e_op2, e_mode);
      e_ovf = ovf; e_err = 1'b0;
    end else begin
      wexp = T; e_res = 32'd0; e_ovf = 1'b0; e_err = 1'b1;
    end

    @(negedge clk);
    chk("gnt", 64'({gnt1, gnt0}), (w == 1) ? 64'd2 : 64'd1);
    chk("start_busy", 64'({add_start, busy, rsp_valid0, rsp_valid1}), 64'b1100);
    chk("op1", 64'(op1), 64'(e_op1));
    chk("op2", 64'(op2), 64'(e_op2));
    chk("mode", 64'(mode), 64'(e_mode));
    last_w = w;
    if (!hold) begin req0 = 1'b0; req1 = 1'b0; end

    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("quiet", 64'({gnt0, gnt1, add_start, busy, mode}), 64'({4'b0001, e_mode}));
      chk("hold_op1", 64'(op1), 64'(e_op1));
    end while (!(rsp_valid0 || rsp_valid1) && n < T + 4);

    chk("resp_lat", 64'(n), 64'(wexp + 1));
    chk("rsp_v", 64'({rsp_valid1, rsp_valid0}), (w == 1) ? 64'd2 : 64'd1);
    chk("rsp_res", 64'(rsp_result), 64'(e_res));
    chk("rsp_flags", 64'({rsp_ovf, rsp_err}), 64'({e_ovf, e_err}));
    got_res = rsp_result;

    @(negedge clk);
    chk("idle", 64'({busy, gnt0, gnt1, rsp_valid0, rsp_valid1, add_start}), 64'd0);
  endtask

  initial begin
    n_rst = 1'b0; req0 = 1'b0; req1 = 1'b0; mode0 = 1'b0; mode1 = 1'b0;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0; stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Ties with both requests held across jobs: grant order 0, 1, 0.
    for (int i = 0; i < 3; i++) begin
      do_job(1'b1, 1'b1, 1'b0, 1'b1, rand_fp(), rand_fp(), rand_fp(), rand_fp(),
             2, 1'b0, 1'b1, res_seen);
      chk("tie_order", 64'(last_w), 64'(i % 2));
    end
    req0 = 1'b0; req1 = 1'b0;

    // 1.0 + 2.0 with a 3-cycle unit.
    do_job(1'b1, 1'b0, 1'b0, 1'b0, 32'h3F800000, 32'h40000000, 32'd0, 32'd0,
           3, 1'b0, 1'b0, res_seen);
    chk("one_plus_two", 64'(res_seen), 64'h40400000);

    // Unit never answers: timeout after T WAIT cycles.
    do_job(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, rand_fp(), rand_fp(),
           0, 1'b0, 1'b0, res_seen);

    // Overflow passthrough.
    do_job(1'b1, 1'b0, 1'b0, 1'b0, rand_fp(), rand_fp(), 32'd0, 32'd0,
           2, 1'b1, 1'b0, res_seen);
    chk("ovf_res", 64'(res_seen), 64'h7F800000);

    // add_done on the last WAIT cycle beats the timeout.
    do_job(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, rand_fp(), rand_fp(),
           T, 1'b0, 1'b0, res_seen);

    // Randomized jobs.
    for (int i = 0; i < 40; i++) begin
      int pat;
      pat = $urandom_range(1, 3);
      do_job(pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rand_fp(), rand_fp(), rand_fp(), rand_fp(),
             $urandom_range(0, T + 2), ($urandom_range(0, 7) == 0), 1'b0, res_seen);
    end

    // Stray add_done while idle is ignored.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("stray_idle", 64'({busy, rsp_valid0, rsp_valid1, gnt0, gnt1}), 64'd0);
      @(negedge clk);
    end

    // Reset during WAIT aborts the job without a response.
    req0 = 1'b1; a0 = rand_fp(); b0 = rand_fp(); unit_lat = 0; unit_ovf_force = 1'b0;
    @(negedge clk);
    chk("rst_job_gnt", 64'({gnt1, gnt0}), 64'd1);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_job_wait", 64'({busy, rsp_valid0, rsp_valid1}), 64'b100);
    n_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midjob_rst");
    n_rst = 1'b1;
    last_w = 1;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_done", 64'({busy, rsp_valid0, rsp_valid1}), 64'd0);
      @(negedge clk);
    end

    // Tie right after reset goes to requester 0 again.
    do_job(1'b1, 1'b1, 1'b1, 1'b0, rand_fp(), rand_fp(), rand_fp(), rand_fp(),
           1, 1'b0, 1'b0, res_seen);
    chk("tie_after_rst", 64'(last_w), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
